// File: rtl/muldiv_seq.sv
// Iterative signed/unsigned multiply and divide unit.
// Results land in HI/LO; divide-by-zero is flagged to control.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE, RUN, FIX, DZ, DONE
  } state_t;

  state_t         state;
  logic           is_div_r;
  logic           neg_q;
  logic           neg_r;
  logic [W-1:0]   mag_b;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic           sa;
  logic           sb;
  logic [W-1:0]   abs_a;
  logic [W-1:0]   abs_b;
  logic           accept;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W+1:0]   div_trial;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  assign sa    = ~op[0] & a[W-1];
  assign sb    = ~op[0] & b[W-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  assign accept = start &&
    (state == IDLE || state == DONE);

  // Multiplier sits in acc[W-1:0] and shifts out as the product fills in.
  assign mul_sum = {1'b0, acc[2*W-1:W]}
    + (acc[0] ? {1'b0, mag_b} : '0);
  assign mul_next = {mul_sum, acc[W-1:1]};

  // Restoring step: remainder in the top half, dividend/quotient below.
  assign div_trial = {1'b0, acc[2*W-1:W-1]}
    - {2'b00, mag_b};
  assign div_next = div_trial[W+1]
    ? {acc[2*W-2:0], 1'b0}
    : {div_trial[W-1:0], acc[W-2:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
  assign rem_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      is_div_r <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mag_b    <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            is_div_r <= op[1];
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            mag_b    <= abs_b;
            acc      <= {{W{1'b0}}, abs_a};
            cnt      <= CW'(W - 1);
            div_zero <= 1'b0;
            if (op[1] && b == '0) begin
              state <= DZ;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= is_div_r ? div_next : mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (is_div_r) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*W-1:W];
            lo <= prod_fix[W-1:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DZ: begin
          div_zero <= 1'b1;
          done     <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
